fair_light_ctrl: RTL and testbench
==================================

# fair_light_ctrl

Parametrised N-lane traffic-light fairness controller: the next generation of the 4-lane arbiter, generalised to `LANES` lanes. It serves lanes round-robin with a per-lane green budget and skips empty lanes. It adds a yellow clearance phase, tick-based timing, emergency preemption that resumes the interrupted lane, and an emergency-only mode. It sits between the per-lane queue counters and the lamp drivers.

## Interface
- `LANES`, 4, number of lanes (2..16)
- `CNT_W`, 4, width of each lane's queue count
- `MAX_GREEN`, 5, maximum green ticks per service (≥1)
- `YELLOW_TICKS`, 2, yellow clearance length in ticks (≥1)
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  2  00/11 off, 01 emergency-only, 10 normal
- `tick`  in  1  timing strobe; normal-mode transitions are evaluated only when high
- `emg`  in  LANES  emergency-vehicle request per lane
- `queue_cnt`  in  LANES*CNT_W  lane i count at bits [i*CNT_W +: CNT_W]
- `green`  out  LANES  one-hot-or-zero green lamps; all others are red
- `yellow`  out  LANES  one-hot-or-zero yellow lamps
- `emg_ack`  out  LANES  one-hot: emergency lane currently being served
- `cur_lane`  out  $clog2(LANES)  lane being served, or last served
- `phase`  out  3  0 IDLE, 1 SCAN, 2 GREEN, 3 YELLOW, 4 EMERG, 5 EMG_ONLY

## Operation
- All outputs are registered. Reset (`rst_n`=0) clears every output to 0, sets phase to IDLE, and clears `ptr`, `gcnt`, `ycnt`, `elane`, and the pending-EMERG flag `pend`.
- Mode checks happen every clock, independent of `tick`. Mode 00/11 forces IDLE next clock, clears all outputs and counters, and sets `ptr`=0.
- Mode 01 forces EMG_ONLY:
  - `green` = `emg_ack` = one-hot of the lowest set `emg` bit, updated every clock, with no yellow.
  - If no `emg` bit is set, all lamps are red.
- Mode 10, entered from IDLE or EMG_ONLY, goes to SCAN with `ptr`=0 and all lamps red.
- SCAN, on tick:
  - If any `emg` bit is set, latch `elane` = lowest set bit and go to EMERG.
  - Otherwise search circularly from `ptr`, including `ptr`, for the first lane with nonzero count. Set `cur_lane` to it, `gcnt`=0, and go to GREEN.
  - If no lane has a nonzero count, stay in SCAN with `ptr` unchanged.
- GREEN (`green[cur_lane]`=1), on tick, rules in priority order:
  - `emg` set and `elane`==`cur_lane`: go to EMERG directly and keep green.
  - `emg` set on another lane: set `pend`=1, `ptr`=`cur_lane` (the interrupted lane is re-served), then go to YELLOW.
  - Count of `cur_lane` == 0, or `gcnt`+1 == `MAX_GREEN`: go to YELLOW with `ptr` = (`cur_lane`+1) mod `LANES`.
  - Otherwise increment `gcnt`.
- YELLOW (`yellow[cur_lane]`=1), on tick:
  - Increment `ycnt`.
  - When `ycnt`+1 == `YELLOW_TICKS`, clear `ycnt`.
  - If `pend` is set or any `emg` bit is set, go to EMERG with `elane` latched. Otherwise go to SCAN.
- EMERG (`green[elane]`=1, `emg_ack[elane]`=1):
  - Other `emg` bits are ignored.
  - On a tick with `emg[elane]`=0: clear `pend`, set `cur_lane`=`elane`, go to YELLOW. The existing `ptr` is kept.
  - A second pending emergency is taken at the end of that YELLOW.
- `ptr` wraps from `LANES`-1 to 0. `gcnt` never exceeds `MAX_GREEN`-1.
- Invariant: at most one bit is set across `green` | `yellow` in any cycle.

## Timing
- Tick-qualified decision at edge k: the new lamps are visible after edge k (one clock latency).
- With `tick` held high, a lane with a large queue gets exactly `MAX_GREEN` green cycles, then `YELLOW_TICKS` yellow cycles.
- `tick`=0 holds state, counters, and lamps in mode 10.
- Mode changes take effect at the next edge regardless of `tick`.
- Emergency latency with `tick` held high:
  - Same lane already green: 1 clock.
  - Different lane green: 1 + `YELLOW_TICKS` clocks.
- `rst_n` asserted mid-GREEN or mid-EMERG clears all lamps asynchronously, with no yellow.

## Test plan
- **Round-robin:** `LANES`=4, tick=1, mode=10, counts {3,0,2,9} held. Green on lane 0 for 5 cycles, yellow 2, lane 2 for 5, lane 3 for 5, then wrap to lane 0. Lane 1 is never green.
- **Early release:** lane 0 count drops to 0 in its 2nd green cycle. Yellow starts on the next edge and the next green is lane 1 (count 4).
- **Preemption:** lane 1 green in cycle 2, `emg`=4'b1000. Yellow on lane 1 for 2 cycles, then `green`=`emg_ack`=4'b1000. After `emg` clears: yellow on lane 3, then lane 1 green again with a fresh budget of 5.
- **Same-lane emergency and EMG_ONLY:** `emg[2]` set while lane 2 is green gives EMERG next clock with no yellow. Mode 01 with `emg`=4'b0110 gives `green`=4'b0010 with no yellow, and all red when `emg`=0.
- **Mode and reset:**
  - Mode switched to 11 mid-YELLOW: all outputs 0 and phase 0 next clock. Returning to 10 restarts at lane 0.
  - `rst_n` pulsed low mid-EMERG: outputs 0 immediately.
  - `tick`=0 for 10 cycles mid-GREEN: lamps and `gcnt` unchanged.
- **Empty intersection:** all counts 0. Phase stays SCAN with all lamps red. A count appearing on lane 3 gives green on lane 3 after the next tick.

Source files
------------

// File: rtl/fair_light_ctrl.sv
// fair_light_ctrl
//   Round-robin traffic-light fairness controller for LANES lanes. Lanes are
//   served in circular order with a green budget of MAX_GREEN ticks, empty
//   lanes are skipped, and every green ends with YELLOW_TICKS of yellow.
//   Emergency requests preempt the current lane, and the interrupted lane is
//   served again afterwards. Mode 01 gives an emergency-only pass-through.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       00/11 off, 01 emergency-only, 10 normal
//   tick       timing strobe qualifying normal-mode transitions
//   emg        per-lane emergency request
//   queue_cnt  packed per-lane queue counts, lane i at [i*CNT_W +: CNT_W]
//   green      one-hot-or-zero green lamps (registered)
//   yellow     one-hot-or-zero yellow lamps (registered)
//   emg_ack    one-hot emergency lane being served (registered)
//   cur_lane   lane being served, or last served (registered)
//   phase      0 IDLE, 1 SCAN, 2 GREEN, 3 YELLOW, 4 EMERG, 5 EMG_ONLY
module fair_light_ctrl #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MAX_GREEN    = 5,
  parameter int unsigned YELLOW_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       tick,
  input  logic [LANES-1:0]           emg,
  input  logic [LANES*CNT_W-1:0]     queue_cnt,
  output logic [LANES-1:0]           green,
  output logic [LANES-1:0]           yellow,
  output logic [LANES-1:0]           emg_ack,
  output logic [$clog2(LANES)-1:0]   cur_lane,
  output logic [2:0]                 phase
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned GW = $clog2(MAX_GREEN + 1);
  localparam int unsigned YW = $clog2(YELLOW_TICKS + 1);
  localparam logic [GW-1:0] GLAST    = GW'(MAX_GREEN - 1);
  localparam logic [YW-1:0] YLAST    = YW'(YELLOW_TICKS - 1);
  localparam logic [LW-1:0] LANE_TOP = LW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_GREEN    = 3'd2,
    S_YELLOW   = 3'd3,
    S_EMERG    = 3'd4,
    S_EMG_ONLY = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   ptr, ptr_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic [YW-1:0]   ycnt, ycnt_n;
  logic [LW-1:0]   elane, elane_n;
  logic            pend, pend_n;
  logic [LW-1:0]   cur_n;
  logic [LANES-1:0] green_n, yellow_n, ack_n;

  logic [CNT_W-1:0] cnt [LANES];
  logic             emg_any;
  logic [LW-1:0]    emg_low;
  logic             found;
  logic [LW-1:0]    scan_lane;
  logic [LW-1:0]    cand;
  int unsigned      idx;

  assign phase = state;

  // Per-lane counts, lowest requesting emergency lane, and the first
  // non-empty lane at or after ptr in circular order.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      cnt[i] = queue_cnt[i*CNT_W +: CNT_W];
    end

    emg_any = 1'b0;
    emg_low = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!emg_any && emg[i]) begin
        emg_any = 1'b1;
        emg_low = LW'(i);
      end
    end

    found     = 1'b0;
    scan_lane = ptr;
    cand      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= LANES) idx = idx - LANES;
      cand = LW'(idx);
      if (!found && cnt[cand] != '0) begin
        found     = 1'b1;
        scan_lane = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gcnt_n  = gcnt;
    ycnt_n  = ycnt;
    elane_n = elane;
    pend_n  = pend;
    cur_n   = cur_lane;

    case (mode)
      2'b01: begin
        state_n = S_EMG_ONLY;
        if (emg_any) cur_n = emg_low;
      end
      2'b10: begin
        if (state == S_IDLE || state == S_EMG_ONLY) begin
          state_n = S_SCAN;
          ptr_n   = '0;
        end else if (tick) begin
          case (state)
            S_SCAN: begin
              if (emg_any) begin
                elane_n = emg_low;
                state_n = S_EMERG;
              end else if (found) begin
                cur_n   = scan_lane;
                gcnt_n  = '0;
                state_n = S_GREEN;
              end
            end
            S_GREEN: begin
              // The emergency target is always the lowest requesting lane;
              // only when that is the lane already green is yellow skipped.
              if (emg_any && emg_low == cur_lane) begin
                elane_n = emg_low;
                state_n = S_EMERG;
              end else if (emg_any) begin
                pend_n  = 1'b1;
                ptr_n   = cur_lane;
                elane_n = emg_low;
                ycnt_n  = '0;
                state_n = S_YELLOW;
              end else if (cnt[cur_lane] == '0 || gcnt == GLAST) begin
                ptr_n   = (cur_lane == LANE_TOP) ? '0 : cur_lane + 1'b1;
                ycnt_n  = '0;
                state_n = S_YELLOW;
              end else begin
                gcnt_n = gcnt + 1'b1;
              end
            end
            S_YELLOW: begin
              if (ycnt == YLAST) begin
                ycnt_n = '0;
                if (emg_any) elane_n = emg_low;
                state_n = (pend || emg_any) ? S_EMERG : S_SCAN;
              end else begin
                ycnt_n = ycnt + 1'b1;
              end
            end
            S_EMERG: begin
              if (!emg[elane]) begin
                pend_n  = 1'b0;
                cur_n   = elane;
                ycnt_n  = '0;
                state_n = S_YELLOW;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_n = S_IDLE;
        ptr_n   = '0;
        gcnt_n  = '0;
        ycnt_n  = '0;
        elane_n = '0;
        pend_n  = 1'b0;
        cur_n   = '0;
      end
    endcase

    green_n  = '0;
    yellow_n = '0;
    ack_n    = '0;
    case (state_n)
      S_GREEN:  green_n[cur_n] = 1'b1;
      S_YELLOW: yellow_n[cur_n] = 1'b1;
      S_EMERG: begin
        green_n[elane_n] = 1'b1;
        ack_n[elane_n]   = 1'b1;
      end
      S_EMG_ONLY: begin
        if (emg_any) begin
          green_n[emg_low] = 1'b1;
          ack_n[emg_low]   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gcnt     <= '0;
      ycnt     <= '0;
      elane    <= '0;
      pend     <= 1'b0;
      cur_lane <= '0;
      green    <= '0;
      yellow   <= '0;
      emg_ack  <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gcnt     <= gcnt_n;
      ycnt     <= ycnt_n;
      elane    <= elane_n;
      pend     <= pend_n;
      cur_lane <= cur_n;
      green    <= green_n;
      yellow   <= yellow_n;
      emg_ack  <= ack_n;
    end
  end

endmodule

// File: tb/tb_fair_light_ctrl.sv
module tb_fair_light_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        tick;
  logic [3:0]  emg;
  logic [15:0] queue_cnt;
  logic [3:0]  green, yellow, emg_ack;
  logic [1:0]  cur_lane;
  logic [2:0]  phase;

  fair_light_ctrl #(
    .LANES(4), .CNT_W(4), .MAX_GREEN(5), .YELLOW_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .tick(tick), .emg(emg),
    .queue_cnt(queue_cnt), .green(green), .yellow(yellow),
    .emg_ack(emg_ack), .cur_lane(cur_lane), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] PI = 3'd0, PS = 3'd1, PG = 3'd2, PY = 3'd3, PE = 3'd4, PO = 3'd5;
  localparam logic [3:0] Z = 4'b0000, L0 = 4'b0001, L1 = 4'b0010, L2 = 4'b0100, L3 = 4'b1000;
  localparam logic [1:0] M10 = 2'b10, M11 = 2'b11, M01 = 2'b01;

  // One cycle: inputs applied before an edge and the outputs required after it.
  typedef struct {
    logic [1:0]  mode;
    logic        tick;
    logic [3:0]  emg;
    logic [15:0] q;
    logic [3:0]  g, y, a;
    logic [2:0]  ph;
    logic [1:0]  cl;
  } vec_t;

  vec_t stim[$];
  vec_t sb[$];
  vec_t v, e;
  int   errors = 0;
  int   checks = 0;
  int   step;

  function automatic void add(input logic [1:0] m, input logic t, input logic [3:0] em,
                              input logic [15:0] q, input logic [3:0] g, input logic [3:0] y,
                              input logic [3:0] a, input logic [2:0] ph, input logic [1:0] cl,
                              input int n);
    vec_t x;
    x.mode = m; x.tick = t; x.emg = em; x.q = q;
    x.g = g; x.y = y; x.a = a; x.ph = ph; x.cl = cl;
    for (int i = 0; i < n; i++) stim.push_back(x);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mode = M10; tick = 1'b1; emg = '0; queue_cnt = 16'h0009;
    repeat (2) @(negedge clk);
    checks++;
    if ({green, yellow, emg_ack, phase, cur_lane} !== 17'd0) begin
      errors++;
      $display("FAIL reset: g=%b y=%b ack=%b ph=%0d lane=%0d, want all 0",
               green, yellow, emg_ack, phase, cur_lane);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [15:0] q;
    q = 16'h9203;
    add(M11, 1, Z, q, Z, Z, Z, PI, 0, 1);
    add(M10, 1, Z, q, Z, Z, Z, PS, 0, 1);
    add(M10, 1, Z, q, L0, Z, Z, PG, 0, 5);
    add(M10, 1, Z, q, Z, L0, Z, PY, 0, 2);
    add(M10, 1, Z, q, Z, Z, Z, PS, 0, 1);
    add(M10, 1, Z, q, L2, Z, Z, PG, 2, 5);
    add(M10, 1, Z, q, Z, L2, Z, PY, 2, 2);
    add(M10, 1, Z, q, Z, Z, Z, PS, 2, 1);
    add(M10, 1, Z, q, L3, Z, Z, PG, 3, 5);
    add(M10, 1, Z, q, Z, L3, Z, PY, 3, 2);
    add(M10, 1, Z, q, Z, Z, Z, PS, 3, 1);
    add(M10, 1, Z, q, L0, Z, Z, PG, 0, 2);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL round_robin[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  task automatic test_early_release();
    add(M11, 1, Z, 16'h0043, Z, Z, Z, PI, 0, 1);
    add(M10, 1, Z, 16'h0043, Z, Z, Z, PS, 0, 1);
    add(M10, 1, Z, 16'h0043, L0, Z, Z, PG, 0, 2);
    add(M10, 1, Z, 16'h0040, Z, L0, Z, PY, 0, 2);
    add(M10, 1, Z, 16'h0040, Z, Z, Z, PS, 0, 1);
    add(M10, 1, Z, 16'h0040, L1, Z, Z, PG, 1, 2);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL early_release[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  task automatic test_preempt();
    logic [15:0] q;
    q = 16'h0040;
    add(M11, 1, Z,  q, Z,  Z,  Z,  PI, 0, 1);
    add(M10, 1, Z,  q, Z,  Z,  Z,  PS, 0, 1);
    add(M10, 1, Z,  q, L1, Z,  Z,  PG, 1, 2);
    add(M10, 1, L3, q, Z,  L1, Z,  PY, 1, 2);
    add(M10, 1, L3, q, L3, Z,  L3, PE, 1, 2);
    add(M10, 1, Z,  q, Z,  L3, Z,  PY, 3, 2);
    add(M10, 1, Z,  q, Z,  Z,  Z,  PS, 3, 1);
    add(M10, 1, Z,  q, L1, Z,  Z,  PG, 1, 5);
    add(M10, 1, Z,  q, Z,  L1, Z,  PY, 1, 1);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL preempt[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  task automatic test_same_lane_emg_only();
    logic [15:0] q;
    q = 16'h0500;
    add(M11, 1, Z,       q, Z,  Z,  Z,  PI, 0, 1);
    add(M10, 1, Z,       q, Z,  Z,  Z,  PS, 0, 1);
    add(M10, 1, Z,       q, L2, Z,  Z,  PG, 2, 1);
    add(M10, 1, L2,      q, L2, Z,  L2, PE, 2, 1);
    add(M10, 1, Z,       q, Z,  L2, Z,  PY, 2, 2);
    add(M10, 1, Z,       q, Z,  Z,  Z,  PS, 2, 1);
    add(M10, 1, Z,       q, L2, Z,  Z,  PG, 2, 1);
    add(M01, 1, 4'b0110, q, L1, Z,  L1, PO, 1, 1);
    add(M01, 0, Z,       q, Z,  Z,  Z,  PO, 1, 1);
    add(M01, 0, L3,      q, L3, Z,  L3, PO, 3, 1);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL same_lane_emg_only[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  task automatic test_mode_reset();
    logic [15:0] q;
    q = 16'h0099;
    // Mode 11 mid-yellow (with tick low), then restart from lane 0,
    // then a same-lane emergency to reach EMERG before the reset pulse.
    add(M11, 1, Z,  q, Z,  Z,  Z,  PI, 0, 1);
    add(M10, 1, Z,  q, Z,  Z,  Z,  PS, 0, 1);
    add(M10, 1, Z,  q, L0, Z,  Z,  PG, 0, 5);
    add(M10, 1, Z,  q, Z,  L0, Z,  PY, 0, 1);
    add(M11, 0, Z,  q, Z,  Z,  Z,  PI, 0, 1);
    add(M10, 1, Z,  q, Z,  Z,  Z,  PS, 0, 1);
    add(M10, 1, Z,  q, L0, Z,  Z,  PG, 0, 1);
    add(M10, 1, L0, q, L0, Z,  L0, PE, 0, 1);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL mode_reset[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end

    // Asynchronous reset mid-EMERG: lamps must drop before any clock edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({green, yellow, emg_ack, phase, cur_lane} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: g=%b y=%b ack=%b ph=%0d lane=%0d, want all 0",
               green, yellow, emg_ack, phase, cur_lane);
    end
    emg = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // tick held low mid-green must freeze lamps and the green budget.
    q = 16'h0900;
    add(M10, 1, Z, q, Z,  Z,  Z, PS, 0, 1);
    add(M10, 1, Z, q, L2, Z,  Z, PG, 2, 2);
    add(M10, 0, Z, q, L2, Z,  Z, PG, 2, 10);
    add(M10, 1, Z, q, L2, Z,  Z, PG, 2, 3);
    add(M10, 1, Z, q, Z,  L2, Z, PY, 2, 1);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL tick_hold[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  task automatic test_empty();
    add(M11, 1, Z, 16'h0000, Z,  Z, Z, PI, 0, 1);
    add(M10, 1, Z, 16'h0000, Z,  Z, Z, PS, 0, 5);
    add(M10, 0, Z, 16'h8000, Z,  Z, Z, PS, 0, 1);
    add(M10, 1, Z, 16'h8000, L3, Z, Z, PG, 3, 2);
    step = 0;
    while (stim.size() > 0) begin
      v = stim.pop_front();
      mode = v.mode; tick = v.tick; emg = v.emg; queue_cnt = v.q;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({green, yellow, emg_ack, phase, cur_lane} !== {e.g, e.y, e.a, e.ph, e.cl}) begin
        errors++;
        $display("FAIL empty[%0d]: g=%b y=%b ack=%b ph=%0d lane=%0d, want g=%b y=%b ack=%b ph=%0d lane=%0d",
                 step, green, yellow, emg_ack, phase, cur_lane, e.g, e.y, e.a, e.ph, e.cl);
      end
      step++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_release();
    test_preempt();
    test_same_lane_emg_only();
    test_mode_reset();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
